rgb_pwm_sweep: RTL and testbench

- Upstream stage of the RGB LED matrix colour path.
- Generates the three single-bit PWM streams, one per colour, that the matrix fan-out stage replicates to all 25 LEDs.
- Duty cycles walk continuously around a six-phase colour wheel (red→yellow→green→cyan→blue→magenta→red), so the matrix displays the whole chromatic palette.
- Outputs are glitch-free: new duty values are applied only at PWM period boundaries.

---
 rtl/rgb_pkg.sv | 13 +
 rtl/rgb_pwm_sweep_channel.sv | 24 ++
 rtl/rgb_pwm_sweep.sv | 92 +++++++++
 tb/tb_rgb_pwm_sweep.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: phase encodings and widths shared by the RGB colour path.
package rgb_pkg;
  localparam int PWM_BITS_DEF = 8;
  localparam int N_LEDS = 25;
  typedef enum logic [2:0] {
    PH_R2Y = 3'd0,
    PH_Y2G = 3'd1,
    PH_G2C = 3'd2,
    PH_C2B = 3'd3,
    PH_B2M = 3'd4,
    PH_M2R = 3'd5
  } phase_t;
endpackage

// File: rtl/rgb_pwm_sweep_channel.sv
// pwm_channel: shadowed duty with a registered compare, so duty changes land only on period boundaries.
module pwm_channel #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_DUTY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         period_end,
  input  logic [W-1:0] pwm_cnt,
  input  logic [W-1:0] duty_next,
  output logic         pwm
);
  logic [W-1:0] shadow;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RST_DUTY;
      pwm    <= 1'b0;
    end else begin
      if (period_end) shadow <= duty_next;
      pwm <= en && (pwm_cnt < shadow);
    end
  end
endmodule

// File: rtl/rgb_pwm_sweep.sv
// rgb_pwm_sweep: three PWM streams whose duties walk a six-phase colour wheel.
module rgb_pwm_sweep
  import rgb_pkg::*;
#(
  parameter int PWM_BITS     = PWM_BITS_DEF,
  parameter int PRESCALE     = 8,
  parameter int STEP_PERIODS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       R_pwm_output,
  output logic       G_pwm_output,
  output logic       B_pwm_output,
  output logic [2:0] phase,
  output logic       cycle_done
);
  localparam int PSW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SPW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] LAST = MAX - 1'b1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(STEP_PERIODS - 1);

  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SPW-1:0]      per_cnt;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b, r_n, g_n, b_n;
  phase_t              ph, ph_n;
  logic                tick, period_end, step, hit, wrap;

  assign tick       = presc == PS_LAST;
  assign period_end = tick && pwm_cnt == LAST;
  assign step       = period_end && per_cnt == SP_LAST && en;
  assign phase      = ph;

  // Only the ramping channel moves; reaching its target ends the phase.
  always_comb begin
    r_n  = duty_r;
    g_n  = duty_g;
    b_n  = duty_b;
    hit  = 1'b0;
    if (step) begin
      unique case (ph)
        PH_R2Y: begin g_n = duty_g + 1'b1; hit = g_n == MAX;  end
        PH_Y2G: begin r_n = duty_r - 1'b1; hit = r_n == '0;   end
        PH_G2C: begin b_n = duty_b + 1'b1; hit = b_n == MAX;  end
        PH_C2B: begin g_n = duty_g - 1'b1; hit = g_n == '0;   end
        PH_B2M: begin r_n = duty_r + 1'b1; hit = r_n == MAX;  end
        PH_M2R: begin b_n = duty_b - 1'b1; hit = b_n == '0;   end
        default: hit = 1'b0;
      endcase
    end
    wrap = hit && ph == PH_M2R;
    ph_n = !hit ? ph : wrap ? PH_R2Y : phase_t'(ph + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      per_cnt    <= '0;
      ph         <= PH_R2Y;
      duty_r     <= MAX;
      duty_g     <= '0;
      duty_b     <= '0;
      cycle_done <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      if (period_end) per_cnt <= per_cnt == SP_LAST ? '0 : per_cnt + 1'b1;
      duty_r     <= r_n;
      duty_g     <= g_n;
      duty_b     <= b_n;
      ph         <= ph_n;
      cycle_done <= wrap;
    end
  end

  pwm_channel #(.W(PWM_BITS), .RST_DUTY(MAX)) u_r (
    .clk(clk), .rst(rst), .en(en), .period_end(period_end),
    .pwm_cnt(pwm_cnt), .duty_next(r_n), .pwm(R_pwm_output)
  );
  pwm_channel #(.W(PWM_BITS), .RST_DUTY('0)) u_g (
    .clk(clk), .rst(rst), .en(en), .period_end(period_end),
    .pwm_cnt(pwm_cnt), .duty_next(g_n), .pwm(G_pwm_output)
  );
  pwm_channel #(.W(PWM_BITS), .RST_DUTY('0)) u_b (
    .clk(clk), .rst(rst), .en(en), .period_end(period_end),
    .pwm_cnt(pwm_cnt), .duty_next(b_n), .pwm(B_pwm_output)
  );
endmodule

// File: tb/tb_rgb_pwm_sweep.sv
// tb_rgb_pwm_sweep: per-period high counts, phase and cycle_done checked through a scoreboard.
module tb_rgb_pwm_sweep;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       r_o, g_o, b_o, cd;
  logic [2:0] phase;

  rgb_pwm_sweep #(.PWM_BITS(4), .PRESCALE(1), .STEP_PERIODS(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .R_pwm_output(r_o), .G_pwm_output(g_o), .B_pwm_output(b_o),
    .phase(phase), .cycle_done(cd)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int g; int b; int ph; int cd;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int k = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Wheel position after k steps: 15 steps per phase, ramping one channel.
  function automatic int duty(input int steps, input int ch);
    int p, i;
    p = (steps / 15) % 6;
    i = steps % 15;
    case (p)
      0: return ch == 0 ? 15 : ch == 1 ? i : 0;
      1: return ch == 0 ? 15 - i : ch == 1 ? 15 : 0;
      2: return ch == 0 ? 0 : ch == 1 ? 15 : i;
      3: return ch == 0 ? 0 : ch == 1 ? 15 - i : 15;
      4: return ch == 0 ? i : ch == 1 ? 0 : 15;
      default: return ch == 0 ? 15 : ch == 1 ? 0 : 15 - i;
    endcase
  endfunction

  function automatic int hi(input int d, input logic [14:0] m);
    int c = 0;
    for (int j = 0; j < 15; j++) if (m[j] && j < d) c++;
    return c;
  endfunction

  // One PWM period; m[j] is en for the clock that presents pwm_cnt==j.
  task automatic run_window(input logic [14:0] m);
    exp_t e;
    e.r  = hi(duty(k, 0), m);
    e.g  = hi(duty(k, 1), m);
    e.b  = hi(duty(k, 2), m);
    e.ph = (k / 15) % 6;
    e.cd = (m[14] && ((k + 1) % 90 == 0)) ? 1 : 0;
    q.push_back(e);
    if (m[14]) k++;
    for (int j = 0; j < 15; j++) begin
      en = m[j];
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_R"}, int'(r_o), 0);
    chk({tag, "_G"}, int'(g_o), 0);
    chk({tag, "_B"}, int'(b_o), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_cd"}, int'(cd), 0);
  endtask

  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= rst;

  int idx = 0, rc = 0, gc = 0, bc = 0, cc = 0, ps = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      idx = 0; rc = 0; gc = 0; bc = 0; cc = 0;
    end else begin
      if (idx == 0) ps = int'(phase);
      rc += int'(r_o);
      gc += int'(g_o);
      bc += int'(b_o);
      cc += int'(cd);
      idx++;
      if (idx == 15) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty: got a period with no expectation queued (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("r_high", rc, e.r);
          chk("g_high", gc, e.g);
          chk("b_high", bc, e.b);
          chk("phase", ps, e.ph);
          chk("cycle_done", cc, e.cd);
        end
        idx = 0; rc = 0; gc = 0; bc = 0; cc = 0;
      end
    end
  end

  initial begin
    repeat (3) begin
      @(posedge clk);
      #2;
      chk_idle("in_reset");
    end
    rst = 1'b0;
    k = 0;
    for (int w = 1; w <= 35; w++) run_window(15'h7fff);
    run_window(15'h001f);
    run_window(15'h0000);
    run_window(15'h0000);
    for (int w = 39; w <= 158; w++) run_window(15'h7fff);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk_idle("mid_reset");
    rst = 1'b0;
    k = 0;
    for (int w = 1; w <= 20; w++) run_window(15'h7fff);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
